// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS controller: FSM states, opcodes, mux encodings, strobe bundle.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    IMMEX,
    IMMWB,
    JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       ext_zero;
    logic       illegal;
    logic       bus_err;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // FETCH doubles as the "unknown opcode" target, so no legal opcode may map to it.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:     nxt = MEMADR;
      OP_RTYPE:         nxt = RTYPEEX;
      OP_BEQ:           nxt = BEQEX;
      OP_ADDI, OP_ORI:  nxt = IMMEX;
      OP_J:             nxt = JEX;
      default:          nxt = FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return decode_next(op) != FETCH;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-strobe decode; zero latency, outputs forced low while reset is held.
// An abort cycle raises bus_err and masks every write strobe.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic       rst_n,
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       abort,
  output ctrl_t      ctrl
);

  logic is_ori;

  assign is_ori = (op_q == OP_ORI);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.illegal   = !op_legal(opcode);
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = is_ori ? ALUOP_OR : ALUOP_ADD;
        ctrl.ext_zero  = is_ori;
      end
      IMMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_zero  = is_ori;
      end
      JEX: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase

    // abort is only ever raised with mem_ready low, so a completing access always wins
    if (abort) begin
      ctrl.bus_err   = 1'b1;
      ctrl.pc_write  = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.reg_write = 1'b0;
    end

    if (!rst_n) ctrl = '0;
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait counter; 3-5 cycles per instruction.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready, aborting to FETCH with bus_err after WAIT_LIMIT waits.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       ext_zero,
  output logic       illegal,
  output logic       bus_err,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic [7:0] wait_cnt_q;
  logic       waiting;
  logic       abort;
  ctrl_t      ctrl;

  always_comb begin
    waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    abort   = waiting && !mem_ready && (wait_cnt_q == WAIT_LIM);

    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE:  state_d = decode_next(opcode);
      MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = MEMWB;
               else if (abort) state_d = FETCH;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready || abort) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      IMMEX:   state_d = IMMWB;
      IMMWB:   state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      // an abort out of FETCH re-enters FETCH, which counts as a fresh entry
      if (abort || (state_d != state_q)) wait_cnt_q <= '0;
      else if (waiting && !mem_ready)    wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  mips_ctrl_outdec u_outdec (
    .rst_n     (rst_n),
    .state     (state_q),
    .op_q      (op_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .abort     (abort),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign ext_zero   = ctrl.ext_zero;
  assign illegal    = ctrl.illegal;
  assign bus_err    = ctrl.bus_err;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected strobe vectors queued with stimulus.
// Two instances share inputs: default WAIT_LIMIT and WAIT_LIMIT=3 for abort boundaries.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       ext_zero;
    logic       illegal;
    logic       bus_err;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ov_t;

  typedef struct packed {
    logic sel;
    ov_t  e;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       a_pcw, a_br, a_iord, a_mrd, a_mwr, a_irw, a_rdst, a_m2r, a_rw, a_srca, a_ez, a_ill, a_berr;
  logic [1:0] a_pcs, a_srcb, a_aop;
  logic       b_pcw, b_br, b_iord, b_mrd, b_mwr, b_irw, b_rdst, b_m2r, b_rw, b_srca, b_ez, b_ill, b_berr;
  logic [1:0] b_pcs, b_srcb, b_aop;

  ov_t obs_a, obs_b;

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  cur_sel  = 1'b0;

  sb_t   q_exp[$];
  string q_tag[$];

  mips_mc_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pcw), .branch(a_br), .iord(a_iord), .mem_read(a_mrd), .mem_write(a_mwr),
    .ir_write(a_irw), .reg_dst(a_rdst), .mem_to_reg(a_m2r), .reg_write(a_rw),
    .alu_src_a(a_srca), .ext_zero(a_ez), .illegal(a_ill), .bus_err(a_berr),
    .pc_src(a_pcs), .alu_src_b(a_srcb), .alu_op(a_aop)
  );

  mips_mc_ctrl #(.WAIT_LIMIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pcw), .branch(b_br), .iord(b_iord), .mem_read(b_mrd), .mem_write(b_mwr),
    .ir_write(b_irw), .reg_dst(b_rdst), .mem_to_reg(b_m2r), .reg_write(b_rw),
    .alu_src_a(b_srca), .ext_zero(b_ez), .illegal(b_ill), .bus_err(b_berr),
    .pc_src(b_pcs), .alu_src_b(b_srcb), .alu_op(b_aop)
  );

  assign obs_a = {a_pcw, a_br, a_iord, a_mrd, a_mwr, a_irw, a_rdst, a_m2r, a_rw,
                  a_srca, a_ez, a_ill, a_berr, a_pcs, a_srcb, a_aop};
  assign obs_b = {b_pcw, b_br, b_iord, b_mrd, b_mwr, b_irw, b_rdst, b_m2r, b_rw,
                  b_srca, b_ez, b_ill, b_berr, b_pcs, b_srcb, b_aop};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected strobe vectors, one per state, straight from the state table.
  function automatic ov_t f_zero();
    ov_t o = '0;
    return o;
  endfunction
  function automatic ov_t f_fetch(input bit rdy);
    ov_t o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy;
    return o;
  endfunction
  function automatic ov_t f_decode(input bit ill);
    ov_t o = '0;
    o.alu_src_b = 2'b11; o.illegal = ill;
    return o;
  endfunction
  function automatic ov_t f_memadr();
    ov_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
    return o;
  endfunction
  function automatic ov_t f_memrd(input bit berr);
    ov_t o = '0;
    o.iord = 1'b1; o.mem_read = 1'b1; o.bus_err = berr;
    return o;
  endfunction
  function automatic ov_t f_memwr(input bit berr);
    ov_t o = '0;
    o.iord = 1'b1; o.mem_write = !berr; o.bus_err = berr;
    return o;
  endfunction
  function automatic ov_t f_memwb();
    ov_t o = '0;
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
    return o;
  endfunction
  function automatic ov_t f_rex();
    ov_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = 2'b10;
    return o;
  endfunction
  function automatic ov_t f_rwb();
    ov_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = 1'b1;
    return o;
  endfunction
  function automatic ov_t f_beq();
    ov_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.branch = 1'b1; o.pc_src = 2'b01;
    return o;
  endfunction
  function automatic ov_t f_immex(input bit ori);
    ov_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = ori ? 2'b11 : 2'b00; o.ext_zero = ori;
    return o;
  endfunction
  function automatic ov_t f_immwb(input bit ori);
    ov_t o = '0;
    o.reg_write = 1'b1; o.ext_zero = ori;
    return o;
  endfunction
  function automatic ov_t f_jex();
    ov_t o = '0;
    o.pc_write = 1'b1; o.pc_src = 2'b10;
    return o;
  endfunction

  // One clock of stimulus; the expectation for that cycle is queued alongside it.
  task automatic step(input string tag, input bit rstn, input logic [5:0] op,
                      input bit rdy, input ov_t e);
    sb_t ent;
    @(posedge clk);
    #1;
    rst_n     = rstn;
    opcode    = op;
    mem_ready = rdy;
    ent.sel   = cur_sel;
    ent.e     = e;
    q_exp.push_back(ent);
    q_tag.push_back(tag);
  endtask

  initial begin
    sb_t   ent;
    string tg;
    forever begin
      @(negedge clk);
      if (q_exp.size() != 0) begin
        ent = q_exp.pop_front();
        tg  = q_tag.pop_front();
        chk(tg, 32'(ent.sel ? obs_b : obs_a), 32'(ent.e));
      end
    end
  end

  initial begin
    ov_t e;
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1;

    for (int i = 0; i < 3; i++) step("reset_zero", 1'b0, 6'h00, 1'b1, f_zero());

    step("lw_fetch",  1'b1, 6'h23, 1'b1, f_fetch(1'b1));
    step("lw_decode", 1'b1, 6'h23, 1'b1, f_decode(1'b0));
    step("lw_memadr", 1'b1, 6'h23, 1'b1, f_memadr());
    step("lw_memrd",  1'b1, 6'h23, 1'b1, f_memrd(1'b0));
    step("lw_memwb",  1'b1, 6'h23, 1'b1, f_memwb());

    step("ori_fetch",  1'b1, 6'h0D, 1'b1, f_fetch(1'b1));
    step("ori_decode", 1'b1, 6'h0D, 1'b1, f_decode(1'b0));
    step("ori_immex",  1'b1, 6'h0D, 1'b1, f_immex(1'b1));
    step("ori_immwb",  1'b1, 6'h0D, 1'b1, f_immwb(1'b1));

    step("addi_fetch",  1'b1, 6'h08, 1'b1, f_fetch(1'b1));
    step("addi_decode", 1'b1, 6'h08, 1'b1, f_decode(1'b0));
    step("addi_immex",  1'b1, 6'h08, 1'b1, f_immex(1'b0));
    step("addi_immwb",  1'b1, 6'h08, 1'b1, f_immwb(1'b0));

    step("sw_fetch",  1'b1, 6'h2B, 1'b1, f_fetch(1'b1));
    step("sw_decode", 1'b1, 6'h2B, 1'b1, f_decode(1'b0));
    step("sw_memadr", 1'b1, 6'h2B, 1'b1, f_memadr());
    for (int i = 0; i < 4; i++) step("sw_memwr_wait", 1'b1, 6'h2B, 1'b0, f_memwr(1'b0));
    step("sw_memwr_done", 1'b1, 6'h2B, 1'b1, f_memwr(1'b0));

    for (int i = 0; i < 2; i++) step("fetch_wait", 1'b1, 6'h00, 1'b0, f_fetch(1'b0));
    step("r_fetch",  1'b1, 6'h00, 1'b1, f_fetch(1'b1));
    step("r_decode", 1'b1, 6'h00, 1'b1, f_decode(1'b0));
    step("r_ex",     1'b1, 6'h00, 1'b1, f_rex());
    step("r_wb",     1'b1, 6'h00, 1'b1, f_rwb());

    step("beq_fetch",  1'b1, 6'h04, 1'b1, f_fetch(1'b1));
    step("beq_decode", 1'b1, 6'h04, 1'b0, f_decode(1'b0));
    step("beq_ex",     1'b1, 6'h04, 1'b0, f_beq());

    step("j_fetch",  1'b1, 6'h02, 1'b1, f_fetch(1'b1));
    step("j_decode", 1'b1, 6'h02, 1'b1, f_decode(1'b0));
    step("j_ex",     1'b1, 6'h02, 1'b1, f_jex());

    step("ill_fetch",  1'b1, 6'h3F, 1'b1, f_fetch(1'b1));
    step("ill_decode", 1'b1, 6'h3F, 1'b1, f_decode(1'b1));
    step("ill_next_fetch", 1'b1, 6'h02, 1'b1, f_fetch(1'b1));
    step("ill_j_decode",   1'b1, 6'h02, 1'b1, f_decode(1'b0));
    step("ill_j_ex",       1'b1, 6'h02, 1'b1, f_jex());

    step("mid_fetch",  1'b1, 6'h23, 1'b1, f_fetch(1'b1));
    step("mid_decode", 1'b1, 6'h23, 1'b1, f_decode(1'b0));
    step("mid_memadr", 1'b1, 6'h23, 1'b1, f_memadr());
    step("mid_memrd",  1'b1, 6'h23, 1'b0, f_memrd(1'b0));
    for (int i = 0; i < 2; i++) step("mid_reset_zero", 1'b0, 6'h23, 1'b1, f_zero());
    step("mid_rel_fetch", 1'b1, 6'h04, 1'b1, f_fetch(1'b1));
    step("mid_beq_decode", 1'b1, 6'h04, 1'b1, f_decode(1'b0));
    step("mid_beq_ex",     1'b1, 6'h04, 1'b1, f_beq());

    // WAIT_LIMIT=3 instance from a fresh reset
    cur_sel = 1'b1;
    for (int i = 0; i < 2; i++) step("w3_reset_zero", 1'b0, 6'h00, 1'b1, f_zero());
    step("w3_lw_fetch",  1'b1, 6'h23, 1'b1, f_fetch(1'b1));
    step("w3_lw_decode", 1'b1, 6'h23, 1'b1, f_decode(1'b0));
    step("w3_lw_memadr", 1'b1, 6'h23, 1'b1, f_memadr());
    for (int i = 0; i < 3; i++) step("w3_memrd_wait", 1'b1, 6'h23, 1'b0, f_memrd(1'b0));
    step("w3_memrd_abort", 1'b1, 6'h23, 1'b0, f_memrd(1'b1));
    step("w3_abort_fetch", 1'b1, 6'h2B, 1'b1, f_fetch(1'b1));

    step("w3_sw_decode", 1'b1, 6'h2B, 1'b1, f_decode(1'b0));
    step("w3_sw_memadr", 1'b1, 6'h2B, 1'b1, f_memadr());
    for (int i = 0; i < 3; i++) step("w3_memwr_wait", 1'b1, 6'h2B, 1'b0, f_memwr(1'b0));
    step("w3_memwr_ready_wins", 1'b1, 6'h2B, 1'b1, f_memwr(1'b0));

    step("w3_sw2_fetch",  1'b1, 6'h2B, 1'b1, f_fetch(1'b1));
    step("w3_sw2_decode", 1'b1, 6'h2B, 1'b1, f_decode(1'b0));
    step("w3_sw2_memadr", 1'b1, 6'h2B, 1'b1, f_memadr());
    for (int i = 0; i < 3; i++) step("w3_sw2_wait", 1'b1, 6'h2B, 1'b0, f_memwr(1'b0));
    step("w3_memwr_abort", 1'b1, 6'h2B, 1'b0, f_memwr(1'b1));

    for (int i = 0; i < 3; i++) step("w3_fetch_wait", 1'b1, 6'h02, 1'b0, f_fetch(1'b0));
    e = f_fetch(1'b0);
    e.bus_err = 1'b1;
    step("w3_fetch_abort", 1'b1, 6'h02, 1'b0, e);
    for (int i = 0; i < 3; i++) step("w3_fetch_rewait", 1'b1, 6'h02, 1'b0, f_fetch(1'b0));
    step("w3_fetch_done", 1'b1, 6'h02, 1'b1, f_fetch(1'b1));
    step("w3_j_decode",   1'b1, 6'h02, 1'b1, f_decode(1'b0));
    step("w3_j_ex",       1'b1, 6'h02, 1'b1, f_jex());

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, the maximum number of cycles spent waiting on mem_ready before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-006 SHALL have outputs pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, illegal, bus_err, each 1 bit: datapath strobes and selects.
REQ-007 SHALL have outputs pc_src (2), alu_src_b (2) and alu_op (2): datapath mux selects and the ALU class code.
REQ-008 ext_zero SHALL select zero-extension (1) or sign-extension (0) of imm[15:0] to 32 bits.

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX.
REQ-010 Any output not listed for a state SHALL be 0.
REQ-011 FETCH SHALL assert mem_read and drive alu_src_b=01 (ALU computes PC+4); on a mem_ready cycle it SHALL also assert ir_write and pc_write, and the next state SHALL be DECODE; otherwise it SHALL remain in FETCH.
REQ-012 DECODE SHALL drive alu_src_b=11 (branch target) and latch opcode into internal op_q; the next state is selected on opcode.
REQ-013 DECODE next-state map: LW(23h)/SW(2Bh)->MEMADR; R-type(00h)->RTYPEEX; BEQ(04h)->BEQEX; ADDI(08h)/ORI(0Dh)->IMMEX; J(02h)->JEX.
REQ-014 In DECODE, any other opcode SHALL pulse illegal for one cycle and the next state SHALL be FETCH.
REQ-015 MEMADR SHALL drive alu_src_a=1 and alu_src_b=10; the next state SHALL be MEMRD if op_q is LW, else MEMWR.
REQ-016 MEMRD SHALL assert iord and mem_read and SHALL wait for mem_ready, then go to MEMWB.
REQ-017 MEMWR SHALL assert iord and mem_write and SHALL wait for mem_ready, then go to FETCH.
REQ-018 MEMWB SHALL assert reg_write and mem_to_reg with reg_dst=0, then go to FETCH.
REQ-019 RTYPEEX SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to RTYPEWB.
REQ-020 RTYPEWB SHALL assert reg_write and reg_dst=1, then go to FETCH.
REQ-021 BEQEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, branch=1 and pc_src=01, then go to FETCH.
REQ-022 IMMEX SHALL drive alu_src_a=1 and alu_src_b=10, with alu_op=00 for ADDI and alu_op=11 for ORI, then go to IMMWB.
REQ-023 IMMEX and IMMWB SHALL assert ext_zero when op_q is ORI.
REQ-024 IMMWB SHALL assert reg_write with reg_dst=0, then go to FETCH.
REQ-025 JEX SHALL assert pc_write with pc_src=10, then go to FETCH.
REQ-026 Minimum cycles per instruction, with mem_ready high on first request: LW 5, SW 4, R-type 4, ADDI/ORI 4, BEQ 3, J 3.
REQ-027 An 8-bit wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and SHALL increment each cycle mem_ready is low there.
REQ-028 When the wait counter equals WAIT_LIMIT with mem_ready still low, the block SHALL pulse bus_err for one cycle, suppress all write strobes that cycle, and go to FETCH.
REQ-029 If mem_ready is high on the abort cycle, completion SHALL win and bus_err SHALL stay 0.
REQ-030 mem_ready SHALL be ignored in all non-waiting states.

Reset
REQ-031 While rst_n=0, state SHALL be FETCH, op_q SHALL be 00h, the wait counter SHALL be 0, and every output SHALL be forced to 0, including FETCH's mem_read.
REQ-032 Reset assertion mid-instruction SHALL abort immediately with no further write strobes; after release, the first active edge begins FETCH.

Structure
REQ-033 Package mips_ctrl_pkg SHALL hold the state enum, the opcode constants, and the alu_op and pc_src/alu_src_b encodings.
REQ-034 The state-to-output decode SHALL be a combinational sub-module, mips_ctrl_outdec; the FSM and counter stay in mips_mc_ctrl.

Verification
REQ-035 Scenario: rst_n=0 for 3 cycles, then release with mem_ready=1 -> all outputs 0 during reset; FETCH mem_read=1, ir_write=1 and pc_write=1 on the first cycle after release.
REQ-036 Scenario: LW (23h), mem_ready=1 throughout -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 exactly in cycle 5.
REQ-037 Scenario: ORI (0Dh) -> ext_zero=1 and alu_op=11 in IMMEX; ext_zero=1 in IMMWB; ADDI (08h) -> ext_zero=0 throughout.
REQ-038 Scenario: SW with mem_ready low for 4 cycles in MEMWR -> mem_write held for 5 cycles; return to FETCH afterwards.
REQ-039 Scenario: WAIT_LIMIT=3, mem_ready stuck low in MEMRD -> bus_err pulses once after 4 MEMRD cycles; no reg_write; next state FETCH.
REQ-040 Scenario: opcode 3Fh in DECODE -> illegal=1 for one cycle, no write strobes, FETCH next.
